// File: rtl/mips_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states
// and a small magnitude helper used when signed operands are reduced to
// unsigned form before iterating.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } muldiv_state_t;

  // Two's-complement magnitude when the operand is treated as signed,
  // the raw value otherwise. 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v,
                                             input logic isSigned);
    return (isSigned && v[XLEN-1]) ? (-v) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider, one quotient bit per cycle over 32 cycles.
// Loads on i_start, iterates on the following 32 edges and pulses o_done
// in the cycle after the last iteration. Results stay stable until the
// next load.
module div_core
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_divisor;
  logic [4:0]      r_count;
  logic            r_busy;
  logic            r_done;

  logic [XLEN:0]   w_partial;
  logic            w_fits;
  logic [XLEN-1:0] w_sub;

  // The partial remainder shifted left with the next dividend bit; when it
  // fits the divisor the difference always fits in 32 bits.
  assign w_partial = {r_rem, r_quo[XLEN-1]};
  assign w_fits    = (w_partial >= {1'b0, r_divisor});
  assign w_sub     = w_partial[XLEN-1:0] - r_divisor;

  // Load operands on start, then shift one quotient bit in per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_quo     <= i_dividend;
        r_rem     <= '0;
        r_divisor <= i_divisor;
        r_count   <= '0;
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        if (w_fits) begin
          r_rem <= w_sub;
          r_quo <= {r_quo[XLEN-2:0], 1'b1};
        end else begin
          r_rem <= w_partial[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], 1'b0};
        end
        r_count <= r_count + 5'd1;
        if (r_count == 5'd31) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit. Multiply is a 32-step shift-add
// on operand magnitudes, division uses div_core; signs are restored in the
// FINISH state. MTHI/MTLO write HI/LO directly from IDLE.
// Build option: define MULT_DIV_FAST_MUL_EN to replace the iterative
// multiply with a single-cycle combinational 32x32 multiplier.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  muldiv_state_t   r_state;
  muldiv_state_t   w_nextState;

  muldiv_op_t      r_op;
  logic [XLEN-1:0] r_a;
  logic [4:0]      r_count;
  logic [63:0]     r_acc;
  logic [XLEN-1:0] r_mcand;
  logic            r_negRes;
  logic            r_negRem;
  logic            r_divZero;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_done;
`ifdef MULT_DIV_FAST_MUL_EN
  logic [XLEN-1:0] r_b;
`endif

  logic            w_isMul;
  logic            w_isDiv;
  logic            w_signed;
  logic            w_bZero;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;
  logic            w_divStart;
  logic            w_divDone;
  logic [XLEN-1:0] w_divQuo;
  logic [XLEN-1:0] w_divRem;
  logic [XLEN:0]   w_sum;
  logic [63:0]     w_accNext;
  logic [63:0]     w_mulProd;
  logic            w_rIsDiv;
  logic [XLEN-1:0] w_finHi;
  logic [XLEN-1:0] w_finLo;

  assign w_isMul  = (op == OP_MULT) || (op == OP_MULTU);
  assign w_isDiv  = (op == OP_DIV)  || (op == OP_DIVU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_bZero  = (b == '0);
  assign w_aMag   = absVal(a, w_signed);
  assign w_bMag   = absVal(b, w_signed);
  assign w_rIsDiv = (r_op == OP_DIV) || (r_op == OP_DIVU);

  // The divider loads on the same edge the top latches the request.
  assign w_divStart = (r_state == IDLE) && start && w_isDiv && !w_bZero;

  div_core u_divCore (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_divStart),
    .i_dividend  (w_aMag),
    .i_divisor   (w_bMag),
    .o_done      (w_divDone),
    .o_quotient  (w_divQuo),
    .o_remainder (w_divRem)
  );

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole accumulator right.
  assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_accNext = {w_sum, r_acc[31:1]};

`ifdef MULT_DIV_FAST_MUL_EN
  logic            w_fastSigned;
  logic [63:0]     w_aExt;
  logic [63:0]     w_bExt;
  assign w_fastSigned = (r_op == OP_MULT);
  assign w_aExt       = {{32{w_fastSigned & r_a[31]}}, r_a};
  assign w_bExt       = {{32{w_fastSigned & r_b[31]}}, r_b};
  assign w_mulProd    = w_aExt * w_bExt;
`else
  assign w_mulProd    = r_negRes ? (64'd0 - r_acc) : r_acc;
`endif

  // Next-state logic: multi-cycle ops run 32 iterations, divide by zero and
  // the fast multiplier go straight to FINISH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start && w_isMul) begin
`ifdef MULT_DIV_FAST_MUL_EN
          w_nextState = FINISH;
`else
          w_nextState = MUL;
`endif
        end else if (start && w_isDiv) begin
          w_nextState = w_bZero ? FINISH : DIV;
        end
      end
      MUL:     if (r_count == 5'd31) w_nextState = FINISH;
      DIV:     if (r_count == 5'd31) w_nextState = FINISH;
      FINISH:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Result selection in FINISH, applying the sign fix-up to magnitudes.
  always_comb begin
    w_finHi = r_hi;
    w_finLo = r_lo;
    if (r_divZero) begin
      w_finHi = r_a;
      w_finLo = '1;
    end else if (w_rIsDiv) begin
      if (w_divDone) begin
        w_finHi = r_negRem ? (-w_divRem) : w_divRem;
        w_finLo = r_negRes ? (-w_divQuo) : w_divQuo;
      end
    end else begin
      w_finHi = w_mulProd[63:32];
      w_finLo = w_mulProd[31:0];
    end
  end

  // State register plus datapath: latch the request, iterate, then commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_op      <= OP_MULT;
      r_a       <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
`ifdef MULT_DIV_FAST_MUL_EN
      r_b       <= '0;
`endif
    end else begin
      r_state <= w_nextState;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op      <= op;
            r_a       <= a;
            r_count   <= '0;
            r_acc     <= {32'd0, w_bMag};
            r_mcand   <= w_aMag;
            r_negRes  <= w_signed & (a[31] ^ b[31]);
            r_negRem  <= (op == OP_DIV) & a[31];
            r_divZero <= w_isDiv & w_bZero;
`ifdef MULT_DIV_FAST_MUL_EN
            r_b       <= b;
`endif
            if (op == OP_MTHI) r_hi <= a;
            if (op == OP_MTLO) r_lo <= a;
          end
        end
        MUL: begin
          r_acc   <= w_accNext;
          r_count <= r_count + 5'd1;
        end
        DIV: begin
          r_count <= r_count + 5'd1;
        end
        FINISH: begin
          r_hi   <= w_finHi;
          r_lo   <= w_finLo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a table of multiply/divide
// vectors with hand-computed HI/LO and start-to-done latency, followed by
// hand-written sequences for MTHI/MTLO, back-to-back starts and reset
// during an operation. Honours MULT_DIV_FAST_MUL_EN for multiply latency.
module tb_mult_div_unit;
  import mips_pkg::*;

`ifdef MULT_DIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat  = 34;
  localparam int ZeroLat = 2;
  localparam int MaxWait = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expLat;
  } vec_t;

  vec_t vecs[11];
  int   errorCount = 0;
  int   checkCount = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one request, check busy after the accepting edge, then wait for
  // done. lat is the cycle index in which done is seen (start cycle = 0).
  task automatic applyStimulus(input muldiv_op_t vOp, input logic [31:0] vA,
                               input logic [31:0] vB, input string name,
                               output int lat);
    start = 1'b1;
    op    = vOp;
    a     = vA;
    b     = vB;
    tick();
    start = 1'b0;
    checkOutput({name, " busy after accept"}, {31'd0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < MaxWait) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int doneSeen;
    string nm;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MulLat};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MulLat};
    vecs[2]  = '{OP_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, MulLat};
    vecs[3]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MulLat};
    vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DivLat};
    vecs[5]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DivLat};
    vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DivLat};
    vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DivLat};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DivLat};
    vecs[9]  = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, ZeroLat};
    vecs[10] = '{OP_DIVU,  32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'hFFFFFFFF, ZeroLat};

    reset = 1'b1;
    start = 1'b0;
    op    = OP_MULT;
    a     = '0;
    b     = '0;
    tick();
    tick();
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);

    // Reset must win over a simultaneous start.
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'hCAFEF00D;
    tick();
    checkOutput("reset priority hi", hi, 32'd0);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd3;
    b     = 32'd3;
    tick();
    checkOutput("reset priority busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      nm = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, nm, lat);
      checkOutput({nm, " hi"}, hi, vecs[i].expHi);
      checkOutput({nm, " lo"}, lo, vecs[i].expLo);
      checkOutput({nm, " latency"}, 32'(lat), 32'(vecs[i].expLat));
      checkOutput({nm, " busy at done"}, {31'd0, busy}, 32'd0);
      tick();
      checkOutput({nm, " done pulse width"}, {31'd0, done}, 32'd0);
    end

    // MTHI from idle: immediate write, LO untouched, no busy/done.
    start = 1'b1;
    op    = OP_MTHI;
    a     = 32'h12345678;
    tick();
    start = 1'b0;
    checkOutput("mthi hi", hi, 32'h12345678);
    checkOutput("mthi lo unchanged", lo, 32'hFFFFFFFF);
    checkOutput("mthi busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("mthi done later", {31'd0, done}, 32'd0);

    // MTLO requested while a DIVU iterates must be ignored.
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    tick();
    op    = OP_MTLO;
    a     = 32'hAAAAAAAA;
    checkOutput("mtlo-busy busy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    start = 1'b0;
    checkOutput("mid-iteration hi stable", hi, 32'h12345678);
    checkOutput("mid-iteration lo stable", lo, 32'hFFFFFFFF);
    lat = 6;
    while (!done && lat < MaxWait) begin
      tick();
      lat++;
    end
    checkOutput("divu 100/7 latency", 32'(lat), 32'(DivLat));
    checkOutput("divu 100/7 hi", hi, 32'd2);
    checkOutput("divu 100/7 lo", lo, 32'd14);

    // A new start in the done cycle is accepted.
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd4;
    tick();
    start = 1'b0;
    checkOutput("back-to-back busy", {31'd0, busy}, 32'd1);
    checkOutput("back-to-back done dropped", {31'd0, done}, 32'd0);
    lat = 1;
    while (!done && lat < MaxWait) begin
      tick();
      lat++;
    end
    checkOutput("divu 9/4 latency", 32'(lat), 32'(DivLat));
    checkOutput("divu 9/4 hi", hi, 32'd1);
    checkOutput("divu 9/4 lo", lo, 32'd2);

    // Reset after ten DIVU iterations aborts with no result and no done.
    start = 1'b1;
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    doneSeen = 0;
    repeat (40) begin
      tick();
      if (done) doneSeen++;
    end
    checkOutput("abort no late done", 32'(doneSeen), 32'd0);

    applyStimulus(OP_DIVU, 32'd7, 32'd2, "post-abort", lat);
    checkOutput("post-abort hi", hi, 32'd1);
    checkOutput("post-abort lo", lo, 32'd3);
    checkOutput("post-abort latency", 32'(lat), 32'(DivLat));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
